// File: rtl/bn_channel_sequencer.sv
// Channel-major sequencer for the INT8 batch-norm datapath: per-channel parameter
// table, input acceptance, per-stage operand alignment and result tagging.
module bn_channel_sequencer #(
    parameter int MAX_CH = 16,
    parameter int CH_W   = 4,
    parameter int ELEM_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_sel,
    input  logic [CH_W-1:0]   cfg_addr,
    input  logic signed [7:0] cfg_wdata,
    input  logic              start,
    input  logic [CH_W:0]     num_channels,
    input  logic [ELEM_W-1:0] elems_per_ch,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic signed [7:0] in_data,
    output logic              bn_en,
    output logic signed [7:0] bn_data,
    output logic signed [7:0] bn_mean,
    output logic signed [7:0] bn_var,
    output logic signed [7:0] bn_gamma,
    output logic signed [7:0] bn_beta,
    input  logic signed [7:0] bn_out,
    output logic              out_valid,
    output logic signed [7:0] out_data,
    output logic              out_last,
    output logic [CH_W-1:0]   out_ch,
    output logic              busy,
    output logic              done
);

    // state | meaning
    // IDLE  | table writable, waiting for start
    // RUN   | accepting elements, issuing elements or bubbles every cycle
    // DRAIN | pipeline flush, bn_en held high for 3 cycles
    // DONE  | one-cycle done pulse, tag pipeline cleared
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam int SEL_MEAN  = 0;
    localparam int SEL_VAR   = 1;
    localparam int SEL_GAMMA = 2;
    localparam int SEL_BETA  = 3;

    state_t state, state_nxt;

    logic signed [7:0] tab [4][MAX_CH];
    logic [CH_W:0]     n_ch;
    logic [ELEM_W-1:0] n_elem;
    logic [ELEM_W-1:0] elem_cnt;
    logic [CH_W-1:0]   ch;
    logic [1:0]        drain_cnt;
    logic signed [7:0] gamma_d;
    logic signed [7:0] beta_d1;
    logic signed [7:0] beta_d2;
    logic [3:0]        tag_v;
    logic [3:0]        tag_l;
    logic [CH_W-1:0]   tag_ch [4];

    logic accept;
    logic elem_tc;
    logic ch_tc;
    logic last_accept;
    logic zero_run;

    assign accept      = in_valid && (state == RUN);
    assign elem_tc     = (elem_cnt == n_elem - ELEM_W'(1));
    assign ch_tc       = ({1'b0, ch} == n_ch - (CH_W+1)'(1));
    assign last_accept = accept && elem_tc && ch_tc;
    assign zero_run    = (num_channels == '0) || (elems_per_ch == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        bn_en     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = zero_run ? DONE : RUN;
                end
            end
            RUN: begin
                in_ready = 1'b1;
                bn_en    = 1'b1;
                if (last_accept) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                bn_en = 1'b1;
                if (drain_cnt == 2'd0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < MAX_CH; j++) begin
                    tab[i][j] <= '0;
                end
            end
        end else if (state == IDLE && cfg_we) begin
            tab[cfg_sel][cfg_addr] <= cfg_wdata;
        end
    end

    // The final accept leaves ch on the last channel so no out-of-range index is formed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_ch      <= '0;
            n_elem    <= '0;
            elem_cnt  <= '0;
            ch        <= '0;
            drain_cnt <= '0;
        end else begin
            if (state == IDLE && start) begin
                n_ch     <= num_channels;
                n_elem   <= elems_per_ch;
                elem_cnt <= '0;
                ch       <= '0;
            end else if (accept) begin
                if (elem_tc) begin
                    elem_cnt <= '0;
                    if (!ch_tc) begin
                        ch <= ch + CH_W'(1);
                    end
                end else begin
                    elem_cnt <= elem_cnt + ELEM_W'(1);
                end
            end
            if (last_accept) begin
                drain_cnt <= 2'd2;
            end else if (state == DRAIN && drain_cnt != 2'd0) begin
                drain_cnt <= drain_cnt - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gamma_d <= '0;
            beta_d1 <= '0;
            beta_d2 <= '0;
        end else begin
            gamma_d <= tab[SEL_GAMMA][ch];
            beta_d1 <= tab[SEL_BETA][ch];
            beta_d2 <= beta_d1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v <= '0;
            tag_l <= '0;
            for (int i = 0; i < 4; i++) begin
                tag_ch[i] <= '0;
            end
        end else if (state == DONE) begin
            tag_v <= '0;
            tag_l <= '0;
            for (int i = 0; i < 4; i++) begin
                tag_ch[i] <= '0;
            end
        end else if (bn_en) begin
            tag_v     <= {tag_v[2:0], accept};
            tag_l     <= {tag_l[2:0], last_accept};
            tag_ch[0] <= accept ? ch : '0;
            for (int i = 1; i < 4; i++) begin
                tag_ch[i] <= tag_ch[i-1];
            end
        end
    end

    assign bn_data   = accept ? in_data : '0;
    assign bn_mean   = tab[SEL_MEAN][ch];
    assign bn_var    = tab[SEL_VAR][ch];
    assign bn_gamma  = gamma_d;
    assign bn_beta   = beta_d2;
    assign out_valid = tag_v[3];
    assign out_last  = tag_l[3];
    assign out_ch    = tag_ch[3];
    assign out_data  = bn_out;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

endmodule

// File: tb/tb_bn_channel_sequencer.sv
// Bench for bn_channel_sequencer: a staged datapath stand-in plus a scoreboard fed
// from a per-element reference formula sat((x - mean) * gamma + beta).
module tb_bn_channel_sequencer;

    localparam int CH_W   = 4;
    localparam int ELEM_W = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cfg_we = 1'b0;
    logic [1:0]        cfg_sel = '0;
    logic [CH_W-1:0]   cfg_addr = '0;
    logic signed [7:0] cfg_wdata = '0;
    logic              start = 1'b0;
    logic [CH_W:0]     num_channels = '0;
    logic [ELEM_W-1:0] elems_per_ch = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic signed [7:0] in_data = '0;
    logic              bn_en;
    logic signed [7:0] bn_data, bn_mean, bn_var, bn_gamma, bn_beta;
    logic signed [7:0] bn_out;
    logic              out_valid;
    logic signed [7:0] out_data;
    logic              out_last;
    logic [CH_W-1:0]   out_ch;
    logic              busy;
    logic              done;

    bn_channel_sequencer #(.MAX_CH(16), .CH_W(CH_W), .ELEM_W(ELEM_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .start(start), .num_channels(num_channels), .elems_per_ch(elems_per_ch),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .bn_en(bn_en), .bn_data(bn_data), .bn_mean(bn_mean), .bn_var(bn_var),
        .bn_gamma(bn_gamma), .bn_beta(bn_beta), .bn_out(bn_out),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ch(out_ch),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    function automatic int sat8(int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    // Stand-in for the 4-stage datapath: operands consumed one per stage while bn_en.
    int d1 = 0, d2 = 0, d3 = 0, d4 = 0;
    always @(posedge clk) begin
        if (bn_en) begin
            d1 <= int'(bn_data) - int'(bn_mean);
            d2 <= d1 * int'(bn_gamma);
            d3 <= d2 + int'(bn_beta);
            d4 <= sat8(d3);
        end
    end
    assign bn_out = d4[7:0];

    typedef struct {
        int val;
        bit last;
        int ch;
        int cyc;
    } exp_t;
    exp_t sb[$];

    int mdl [4][16];
    int data_q[$];

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_data", int'(out_data), e.val);
                chk("out_last", int'(out_last), int'(e.last));
                chk("out_ch", int'(out_ch), e.ch);
                chk("out_latency", cyc, e.cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        start  = 1'b0;
        cfg_we = 1'b0;
    endtask

    task automatic cfg(int sel, int addr, int val);
        step();
        cfg_we    = 1'b1;
        cfg_sel   = sel[1:0];
        cfg_addr  = addr[CH_W-1:0];
        cfg_wdata = val[7:0];
        mdl[sel][addr] = val;
        step();
    endtask

    task automatic do_run(int nc, int ne, int maxgap, bit poke);
        int s, last_cyc, x, k, idx;
        step();
        start        = 1'b1;
        num_channels = nc[CH_W:0];
        elems_per_ch = ne[ELEM_W-1:0];
        @(negedge clk);
        s = cyc;
        step();
        if (nc == 0 || ne == 0) begin
            @(negedge clk);
            chk("zero_done", int'(done), 1);
            chk("zero_done_cycle", cyc, s + 1);
            chk("zero_busy", int'(busy), 1);
            @(negedge clk);
            chk("zero_done_clear", int'(done), 0);
            chk("zero_idle", int'(busy), 0);
            return;
        end
        last_cyc = 0;
        idx = 0;
        for (int c = 0; c < nc; c++) begin
            for (int e = 0; e < ne; e++) begin
                repeat ($urandom_range(0, maxgap)) begin
                    in_valid = 1'b0;
                    step();
                end
                x = (data_q.size() != 0) ? data_q.pop_front() : int'($urandom_range(0, 255)) - 128;
                in_valid = 1'b1;
                in_data  = x[7:0];
                if (poke && idx == 1) begin
                    start     = 1'b1;
                    num_channels = '0;
                    cfg_we    = 1'b1;
                    cfg_sel   = 2'd2;
                    cfg_addr  = '0;
                    cfg_wdata = 8'sd9;
                end
                @(negedge clk);
                chk("in_ready", int'(in_ready), 1);
                sb.push_back('{val: sat8((x - mdl[0][c]) * mdl[2][c] + mdl[3][c]),
                               last: (c == nc - 1) && (e == ne - 1), ch: c, cyc: cyc + 4});
                last_cyc = cyc;
                idx++;
                step();
            end
        end
        in_valid = 1'b0;
        for (k = 0; k < 16; k++) begin
            @(negedge clk);
            if (done) break;
        end
        chk("done_cycle", cyc, last_cyc + 4);
        @(negedge clk);
        chk("done_one_cycle", int'(done), 0);
        chk("idle_after_done", int'(busy), 0);
        chk("scoreboard_drained", sb.size(), 0);
    endtask

    task automatic chk_all_zero(string tag);
        chk({tag, "_in_ready"}, int'(in_ready), 0);
        chk({tag, "_bn_en"}, int'(bn_en), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_out_last"}, int'(out_last), 0);
        chk({tag, "_bn_gamma"}, int'(bn_gamma), 0);
        chk({tag, "_bn_beta"}, int'(bn_beta), 0);
        chk({tag, "_bn_mean"}, int'(bn_mean), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 16; j++)
                mdl[i][j] = 0;
        #3;
        chk_all_zero("reset");
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        cfg(0, 0, 10); cfg(2, 0, 2); cfg(3, 0, 5);
        data_q = '{20, 11, 10};
        do_run(1, 3, 0, 1'b0);

        cfg(0, 0, -100);
        data_q = '{100};
        do_run(1, 1, 0, 1'b0);
        cfg(0, 0, 100);
        data_q = '{-100};
        do_run(1, 1, 0, 1'b0);

        cfg(0, 0, 10); cfg(0, 1, 0); cfg(2, 1, 1); cfg(3, 1, -3);
        data_q = '{20, 11, 7, 9};
        do_run(2, 2, 3, 1'b0);

        do_run(0, 3, 0, 1'b0);
        do_run(2, 0, 0, 1'b0);

        do_run(1, 3, 1, 1'b1);
        do_run(1, 2, 0, 1'b0);

        for (int j = 0; j < 16; j++) begin
            cfg(0, j, int'($urandom_range(0, 255)) - 128);
            cfg(1, j, int'($urandom_range(0, 255)) - 128);
            cfg(2, j, int'($urandom_range(0, 255)) - 128);
            cfg(3, j, int'($urandom_range(0, 255)) - 128);
        end
        for (int r = 0; r < 5; r++)
            do_run(int'($urandom_range(1, 4)), int'($urandom_range(1, 5)), 2, 1'b0);
        do_run(16, 2, 1, 1'b0);

        step();
        start = 1'b1; num_channels = 5'd2; elems_per_ch = 16'd4;
        step();
        in_valid = 1'b1; in_data = 8'sd5;
        step();
        in_data = 8'sd6;
        step();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 16; j++)
                mdl[i][j] = 0;
        sb.delete();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        do_run(1, 2, 0, 1'b0);

        cfg(0, 0, 10); cfg(2, 0, 2); cfg(3, 0, 5);
        cfg(0, 1, 0); cfg(2, 1, 1); cfg(3, 1, -3);
        do_run(2, 3, 2, 1'b0);

        repeat (6) @(negedge clk);
        chk("final_scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bn_channel_sequencer.md
# bn_channel_sequencer

Channel-major sequencer for the INT8 batch-norm datapath (`batch_norm_int8`). It holds a per-channel parameter table (mean, var, gamma, beta) written over a config port. It accepts an input element stream, drives the datapath's enable and parameter inputs with the per-stage alignment the 4-stage pipeline requires, and tags results with valid/last/channel. It sits between the layer DMA/stream source and the batch-norm datapath instance.

## Interface
- MAX_CH, 16, channel table depth
- CH_W, 4, channel index width (log2 MAX_CH)
- ELEM_W, 16, elements-per-channel counter width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cfg_we  in  1  table write strobe (honoured only in IDLE)
- cfg_sel  in  2  0 mean, 1 var, 2 gamma, 3 beta
- cfg_addr  in  CH_W  channel index
- cfg_wdata  in  8  signed parameter value
- start  in  1  run request (honoured only in IDLE)
- num_channels  in  CH_W+1  channels in run, sampled at start
- elems_per_ch  in  ELEM_W  elements per channel, sampled at start
- in_valid / in_ready  in / out  1  input element handshake
- in_data  in  8  signed element
- bn_en  out  1  datapath enable
- bn_data, bn_mean, bn_var, bn_gamma, bn_beta  out  8 each  datapath operands
- bn_out  in  8  datapath result (out_data)
- out_valid  out  1  result valid
- out_data  out  8  result, equals bn_out
- out_last  out  1  final element of run
- out_ch  out  CH_W  channel of result
- busy  out  1  high outside IDLE
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: in_ready=0, bn_en=0. cfg_we writes table[cfg_sel][cfg_addr]. On start, latch sizes and clear counters. If num_channels==0 or elems_per_ch==0, go to DONE; else go to RUN.
- RUN: in_ready=1, bn_en=1 every cycle. An accepted element (in_valid&in_ready) is issued with bn_data=in_data, bn_mean/bn_var=table[ch]. A non-accepted cycle issues a bubble: bn_data=0, tag 0.
- Element counter increments on accept; at elems_per_ch-1 it wraps to 0 and ch increments. Accepting the last element of channel num_channels-1 moves to DRAIN.
- DRAIN: in_ready=0, bn_en=1 for exactly 3 cycles, then DONE.
- DONE: bn_en=0, done=1 for one cycle. Clear the tag pipeline, then go to IDLE.
- Operand alignment: gamma of the issued element's channel is registered once, so it is presented one cycle after issue. Beta is registered twice, presented two cycles after issue.
- Tag pipeline: 4 stages of {valid, last, ch}, shifted only when bn_en=1. Stage 0 is loaded at issue.
- out_valid/out_last/out_ch are driven from stage 3. out_data=bn_out.
- start and cfg_we are ignored outside IDLE. The table is unaffected by runs.
- Arithmetic and saturation are entirely in the datapath; the sequencer does no math.

## Timing
- Reset: state IDLE; counters, tags, delayed gamma/beta and the table cleared to 0. All outputs 0 (in_ready=0, bn_en=0, busy=0, done=0, out_valid=0).
- Reset mid-run aborts immediately. No done pulse; the next run needs a new start.
- start seen in IDLE cycle s → busy=1 from s+1. Acceptance is possible from s+1.
- Element accepted in cycle n → out_valid with its result in cycle n+4, provided bn_en stays high through n+3. This is guaranteed by RUN/DRAIN.
- Last accept in cycle L → DRAIN cycles L+1..L+3, DONE in L+4 with out_valid=out_last=done=1. IDLE in L+5.
- Zero-size run: start in s → DONE in s+1 (done=1, no out_valid), IDLE in s+2.
- Bubbles never produce out_valid. Results stay in acceptance order.
- A cfg_we in the same cycle as start is honoured (still IDLE).

## Test plan
- Config ch0 mean=10, gamma=2, beta=5; run 1×3 with in 20, 11, 10 back-to-back → outputs 25, 7, 5 in cycles n+4..n+6; out_last on 5; done in the same cycle.
- Saturation: ch0 mean=-100, gamma=2, beta=5, in 100 → 127. Then mean=100, in -100 → -128.
- Two channels × 2 elems (ch1 mean=0, gamma=1, beta=-3; in 7, 9) with in_valid gaps of 0–3 cycles → 4 outputs; out_ch 0,0,1,1; ch1 results 4, 6; no out_valid on bubbles.
- Zero sizes: num_channels=0 → done one cycle after start, no outputs. Same for elems_per_ch=0.
- start and cfg_we (ch0 gamma=9) asserted during RUN → ignored; results use the old gamma; the table still reads the old value afterwards.
- rst_n low mid-RUN → all outputs 0 asynchronously, table cleared. A fresh config+run after reset produces correct results.
